// File: rtl/bnn_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bnn_pkg: shared sequencer state encoding and PE-array width helpers.   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package bnn_pkg;

  localparam int NUM_PES = 8 * 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_e;

  function automatic int num_pes(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int pc_width(input int rows, input int cols, input int word);
    return $clog2(rows * cols * word + 1);
  endfunction

  function automatic int tot_width(input int rows, input int cols, input int depth,
                                   input int word);
    return $clog2(rows * cols * depth * word + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_pc_accum.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bnn_pc_accum: beat counter, popcount total and signed dot result.      |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module bnn_pc_accum
  import bnn_pkg::*;
#(
  parameter int LEN_W         = 7,
  parameter int PC_W          = 13,
  parameter int TOT_W         = 19,
  parameter int BITS_PER_BEAT = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    accept_en,
  input  logic                    load_result,
  input  logic                    pe_pc_valid,
  input  logic [PC_W-1:0]         pe_pc,
  input  logic [LEN_W-1:0]        len,
  output logic [LEN_W-1:0]        beat_cnt_next,
  output logic [TOT_W-1:0]        total_popcount,
  output logic signed [TOT_W:0]   result
);

  logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [TOT_W-1:0]      total_q, total_d;
  logic signed [TOT_W:0] result_q, result_d;
  logic [TOT_W:0]        bias;

  // The result always fits TOT_W+1 signed bits, so modular arithmetic is exact.
  assign bias = (TOT_W+1)'(len) * (TOT_W+1)'(BITS_PER_BEAT);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    total_d    = total_q;
    if (clear) begin
      beat_cnt_d = '0;
      total_d    = '0;
    end else if (accept_en && pe_pc_valid) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
      total_d    = total_q + TOT_W'(pe_pc);
    end
  end

  // Loaded from the next-cycle total so the value is valid while done is high.
  always_comb begin
    result_d = result_q;
    if (load_result) begin
      result_d = $signed({total_d, 1'b0} - bias);
    end else if (clear) begin
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_cnt_q <= '0;
      total_q    <= '0;
      result_q   <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      total_q    <= total_d;
      result_q   <= result_d;
    end
  end

  assign beat_cnt_next  = beat_cnt_d;
  assign total_popcount = total_q;
  assign result         = result_q;

endmodule
`default_nettype wire

// File: rtl/bnn_layer_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bnn_layer_sequencer: SRAM write arbitration, read sequencing, PE ctrl. |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter int  WORD_SIZE  = 64,
  parameter int  SRAM_DEPTH = 64,
  parameter int  PE_ROWS    = 8,
  parameter int  PE_COLS    = 8,
  parameter int  ADDR_W     = $clog2(SRAM_DEPTH),
  localparam int PC_W       = pc_width(PE_ROWS, PE_COLS, WORD_SIZE),
  localparam int TOT_W      = tot_width(PE_ROWS, PE_COLS, SRAM_DEPTH, WORD_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W:0]       len,
  output logic                  busy,
  output logic                  done,
  input  logic                  host_wr_valid,
  output logic                  host_wr_ready,
  input  logic [ADDR_W-1:0]     host_wr_addr,
  input  logic [WORD_SIZE-1:0]  host_wr_data,
  input  logic                  host_wr_type,
  output logic                  sram_wr_en,
  output logic [ADDR_W-1:0]     sram_wr_addr,
  output logic [WORD_SIZE-1:0]  sram_wr_data,
  output logic                  sram_wr_type,
  output logic                  sram_rd_en,
  output logic [ADDR_W-1:0]     sram_rd_addr,
  output logic                  pe_clear,
  output logic                  pe_valid,
  input  logic                  pe_pc_valid,
  input  logic [PC_W-1:0]       pe_pc,
  output logic [TOT_W-1:0]      total_popcount,
  output logic signed [TOT_W:0] result
);

  localparam int             BITS_PER_BEAT = num_pes(PE_ROWS, PE_COLS) * WORD_SIZE;
  localparam logic [ADDR_W:0] DEPTH_LEN    = (ADDR_W+1)'(SRAM_DEPTH);

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] issue_q, issue_d;
  logic            pe_valid_q, pe_valid_d;
  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] beat_cnt_next;
  logic            accum_clear, accept_en, load_result;

  assign len_clamped = (len > DEPTH_LEN) ? DEPTH_LEN : len;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issue_d    = issue_q;
    pe_clear   = 1'b0;
    sram_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len_clamped;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        pe_clear = 1'b1;
        issue_d  = '0;
        state_d  = (len_q != '0) ? ISSUE : FINISH;
      end
      ISSUE: begin
        sram_rd_en = 1'b1;
        issue_d    = issue_q + 1'b1;
        if (issue_q == len_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        // Counting the beat landing this cycle lets done follow the last beat directly.
        if (beat_cnt_next >= len_q) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pe_valid_d = sram_rd_en;
  end

  assign accum_clear = (state_q == CLEAR);
  assign accept_en   = (state_q == ISSUE) || (state_q == DRAIN);
  assign load_result = (state_d == FINISH) && (state_q != FINISH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issue_q    <= '0;
      pe_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      pe_valid_q <= pe_valid_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FINISH);
  assign host_wr_ready = (state_q == IDLE);
  assign sram_wr_en    = host_wr_valid & host_wr_ready;
  assign sram_wr_addr  = host_wr_addr;
  assign sram_wr_data  = host_wr_data;
  assign sram_wr_type  = host_wr_type;
  assign sram_rd_addr  = issue_q[ADDR_W-1:0];
  assign pe_valid      = pe_valid_q;

  bnn_pc_accum #(
    .LEN_W         (ADDR_W + 1),
    .PC_W          (PC_W),
    .TOT_W         (TOT_W),
    .BITS_PER_BEAT (BITS_PER_BEAT)
  ) u_accum (
    .clk            (clk),
    .reset          (reset),
    .clear          (accum_clear),
    .accept_en      (accept_en),
    .load_result    (load_result),
    .pe_pc_valid    (pe_pc_valid),
    .pe_pc          (pe_pc),
    .len            (len_q),
    .beat_cnt_next  (beat_cnt_next),
    .total_popcount (total_popcount),
    .result         (result)
  );

endmodule
`default_nettype wire

// File: tb/tb_bnn_layer_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bnn_layer_sequencer: table-driven and randomized runs with a PE     |
// | loopback responder of configurable latency. Revision: 1.0              |
// +-----------------------------------------------------------------------+
module tb_bnn_layer_sequencer;
  import bnn_pkg::*;

  localparam int WORD_SIZE     = 64;
  localparam int SRAM_DEPTH    = 64;
  localparam int ADDR_W        = 6;
  localparam int PC_W          = 13;
  localparam int TOT_W         = 19;
  localparam int BITS_PER_BEAT = NUM_PES * WORD_SIZE;
  localparam int KIND_MAX = 0, KIND_ZERO = 1, KIND_RAND = 2;

  typedef struct {
    int len;
    int dly;
    int kind;
    int exp_lat;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_W:0]       len = '0;
  logic                  busy, done;
  logic                  host_wr_valid = 1'b0;
  logic                  host_wr_ready;
  logic [ADDR_W-1:0]     host_wr_addr = '0;
  logic [WORD_SIZE-1:0]  host_wr_data = '0;
  logic                  host_wr_type = 1'b0;
  logic                  sram_wr_en;
  logic [ADDR_W-1:0]     sram_wr_addr;
  logic [WORD_SIZE-1:0]  sram_wr_data;
  logic                  sram_wr_type;
  logic                  sram_rd_en;
  logic [ADDR_W-1:0]     sram_rd_addr;
  logic                  pe_clear, pe_valid;
  logic                  pe_pc_valid = 1'b0;
  logic [PC_W-1:0]       pe_pc = '0;
  logic [TOT_W-1:0]      total_popcount;
  logic signed [TOT_W:0] result;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat_d = 0;
  int done_count = 0;
  bit force_beat = 1'b0;
  logic [PC_W-1:0] pc_src[$];
  int              pend_due[$];
  logic [PC_W-1:0] pend_pc[$];
  int              addr_q[$];

  bnn_layer_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .len            (len),
    .busy           (busy),
    .done           (done),
    .host_wr_valid  (host_wr_valid),
    .host_wr_ready  (host_wr_ready),
    .host_wr_addr   (host_wr_addr),
    .host_wr_data   (host_wr_data),
    .host_wr_type   (host_wr_type),
    .sram_wr_en     (sram_wr_en),
    .sram_wr_addr   (sram_wr_addr),
    .sram_wr_data   (sram_wr_data),
    .sram_wr_type   (sram_wr_type),
    .sram_rd_en     (sram_rd_en),
    .sram_rd_addr   (sram_rd_addr),
    .pe_clear       (pe_clear),
    .pe_valid       (pe_valid),
    .pe_pc_valid    (pe_pc_valid),
    .pe_pc          (pe_pc),
    .total_popcount (total_popcount),
    .result         (result)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PE array stand-in: each pe_valid beat returns a queued popcount lat_d cycles later.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      pend_due.delete();
      pend_pc.delete();
    end else if (pe_valid) begin
      pend_due.push_back(cyc + lat_d);
      if (pc_src.size() > 0) pend_pc.push_back(pc_src.pop_front());
      else pend_pc.push_back('0);
    end
    if (sram_rd_en) addr_q.push_back(int'(sram_rd_addr));
    if (done) done_count++;
    if (force_beat) begin
      pe_pc_valid = 1'b1;
      pe_pc       = PC_W'(1234);
    end else if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      pe_pc_valid = 1'b1;
      pe_pc       = pend_pc[0];
      void'(pend_due.pop_front());
      void'(pend_pc.pop_front());
    end else begin
      pe_pc_valid = 1'b0;
      pe_pc       = '0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp_len(input int l);
    return (l > SRAM_DEPTH) ? SRAM_DEPTH : l;
  endfunction

  // Done arrives one cycle after the last beat; the last beat is dly cycles after
  // the last pe_valid, which follows the last of the issue cycles.
  function automatic int model_lat(input int l, input int d);
    int c;
    c = clamp_len(l);
    return (c == 0) ? 2 : c + 3 + d;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int c, k, waited;
    longint exp_total, exp_res;
    logic [PC_W-1:0] p;
    bit ok;
    c = clamp_len(v.len);
    pc_src.delete();
    exp_total = 0;
    for (int i = 0; i < c; i++) begin
      if (v.kind == KIND_MAX) p = PC_W'(BITS_PER_BEAT);
      else if (v.kind == KIND_ZERO) p = '0;
      else p = PC_W'($urandom_range(0, BITS_PER_BEAT));
      pc_src.push_back(p);
      exp_total += longint'(p);
    end
    exp_res = 2 * exp_total - longint'(c) * BITS_PER_BEAT;
    lat_d = v.dly;
    addr_q.delete();
    done_count = 0;
    len   = (ADDR_W+1)'(v.len);
    start = 1'b1;
    k     = cyc;
    step();
    start  = 1'b0;
    waited = 0;
    while (!done && waited < 400) begin
      step();
      waited++;
    end
    if (!done) begin
      check({tag, "_done_timeout"}, 0, 1);
      return;
    end
    check({tag, "_done_lat"}, cyc - k, v.exp_lat);
    check({tag, "_total"}, total_popcount, exp_total);
    check({tag, "_result"}, result, exp_res);
    ok = (addr_q.size() == c);
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) ok = 1'b0;
    check({tag, "_addr_seq"}, ok, 1);
    step();
    check({tag, "_hold_total"}, total_popcount, exp_total);
    check({tag, "_hold_result"}, result, exp_res);
    check({tag, "_idle_after"}, busy, 0);
    repeat (3) step();
    check({tag, "_one_done"}, done_count, 1);
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   bad, waited;
  logic [WORD_SIZE-1:0] wdata;

  initial begin
    tbl[0] = '{len: 64,  dly: 0, kind: KIND_MAX,  exp_lat: 67};
    tbl[1] = '{len: 1,   dly: 5, kind: KIND_ZERO, exp_lat: 9};
    tbl[2] = '{len: 0,   dly: 0, kind: KIND_RAND, exp_lat: 2};
    tbl[3] = '{len: 100, dly: 0, kind: KIND_RAND, exp_lat: 67};
    tbl[4] = '{len: 17,  dly: 3, kind: KIND_RAND, exp_lat: 23};
    tbl[5] = '{len: 5,   dly: 1, kind: KIND_MAX,  exp_lat: 9};

    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", host_wr_ready, 1);
    check("rst_total", total_popcount, 0);
    check("rst_result", result, 0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 4; i++) begin
      rv.len     = $urandom_range(0, 100);
      rv.dly     = $urandom_range(0, 6);
      rv.kind    = KIND_RAND;
      rv.exp_lat = model_lat(rv.len, rv.dly);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // Start and write in the same IDLE cycle, then the write held through the run.
    pc_src.delete();
    lat_d = 0;
    done_count = 0;
    wdata = {$urandom, $urandom};
    host_wr_valid = 1'b1;
    host_wr_addr  = 6'd5;
    host_wr_data  = wdata;
    host_wr_type  = 1'b1;
    len   = 7'd8;
    start = 1'b1;
    #1;
    check("wr_with_start_en", sram_wr_en, 1);
    check("wr_addr_pass", sram_wr_addr, 5);
    check("wr_data_pass", (sram_wr_data == wdata) ? 1 : 0, 1);
    check("wr_type_pass", sram_wr_type, 1);
    step();
    start = 1'b0;
    check("wr_start_taken", busy, 1);
    bad = 0;
    waited = 0;
    while (busy && waited < 200) begin
      if (sram_wr_en || host_wr_ready) bad++;
      step();
      waited++;
    end
    check("wr_stalled_in_run", bad, 0);
    check("wr_run_ended", busy, 0);
    check("wr_after_finish", sram_wr_en, 1);
    check("wr_run_done_once", done_count, 1);
    host_wr_valid = 1'b0;
    step();

    // A second start mid-run must neither restart nor queue a run.
    pc_src.delete();
    for (int i = 0; i < 10; i++) pc_src.push_back(PC_W'(BITS_PER_BEAT));
    lat_d = 2;
    done_count = 0;
    len   = 7'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    waited = 0;
    while (busy && waited < 200) begin
      step();
      waited++;
    end
    repeat (5) step();
    check("repulse_one_done", done_count, 1);
    check("repulse_total", total_popcount, 10 * BITS_PER_BEAT);
    check("repulse_busy", busy, 0);

    force_beat = 1'b1;
    step();
    step();
    force_beat = 1'b0;
    step();
    step();
    check("idle_beat_ignored", total_popcount, 10 * BITS_PER_BEAT);

    // Reset while address 20 is being issued.
    pc_src.delete();
    lat_d = 0;
    done_count = 0;
    len   = 7'd64;
    start = 1'b1;
    step();
    start = 1'b0;
    waited = 0;
    while (!(sram_rd_en && sram_rd_addr == 6'd20) && waited < 100) begin
      step();
      waited++;
    end
    check("mid_reset_reached_addr20", (sram_rd_en && sram_rd_addr == 6'd20) ? 1 : 0, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_ready", host_wr_ready, 1);
    check("mid_reset_total", total_popcount, 0);
    check("mid_reset_result", result, 0);
    repeat (80) step();
    check("mid_reset_no_done", done_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
